// File: rtl/seq_mod_unit.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle, start/busy/done handshake.
// rem/quot/dz are registered and held until the next completed operation.
module seq_mod_unit #(
  parameter int DATAWIDTH = 64
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] c,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] rem,
  output logic [DATAWIDTH-1:0] quot,
  output logic                 dz
);

  localparam int CW = $clog2(DATAWIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]           state_reg;
  logic [CW-1:0]        count_reg;
  logic [DATAWIDTH:0]   prem_reg;
  logic [DATAWIDTH-1:0] dvd_reg;
  logic [DATAWIDTH-1:0] div_reg;
  logic [DATAWIDTH-1:0] rem_reg;
  logic [DATAWIDTH-1:0] quot_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 dz_reg;

  logic [DATAWIDTH+1:0] trial;
  logic                 commit;
  logic [DATAWIDTH:0]   prem_next;
  logic                 accept;

  // Trial subtraction on the shifted partial remainder; the top bit is the borrow.
  assign trial     = {prem_reg, dvd_reg[DATAWIDTH-1]} - {2'b00, div_reg};
  assign commit    = ~trial[DATAWIDTH+1];
  assign prem_next = commit ? trial[DATAWIDTH:0]
                            : {prem_reg[DATAWIDTH-1:0], dvd_reg[DATAWIDTH-1]};

  // FIN accepts a new request so operations can run back to back.
  assign accept = start && !busy_reg && (state_reg == IDLE || state_reg == FIN);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      prem_reg  <= '0;
      dvd_reg   <= '0;
      div_reg   <= '0;
      rem_reg   <= '0;
      quot_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      dz_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          state_reg <= IDLE;
        end
        RUN: begin
          prem_reg  <= prem_next;
          dvd_reg   <= {dvd_reg[DATAWIDTH-2:0], commit};
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            state_reg <= FIN;
            busy_reg  <= 1'b0;
          end
        end
        FIN: begin
          // A zero divisor skips RUN, so dvd_reg still holds the dividend.
          if (div_reg == '0) begin
            rem_reg  <= dvd_reg;
            quot_reg <= '1;
            dz_reg   <= 1'b1;
          end else begin
            rem_reg  <= prem_reg[DATAWIDTH-1:0];
            quot_reg <= dvd_reg;
            dz_reg   <= 1'b0;
          end
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase

      if (accept) begin
        dvd_reg   <= a;
        div_reg   <= c;
        prem_reg  <= '0;
        count_reg <= CW'(DATAWIDTH);
        busy_reg  <= 1'b1;
        state_reg <= (c == '0) ? FIN : RUN;
      end
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign rem  = rem_reg;
  assign quot = quot_reg;
  assign dz   = dz_reg;

endmodule

// File: tb/tb_seq_mod_unit.sv
// Self-checking bench for seq_mod_unit (DATAWIDTH=64): expected results come from
// plain / and % arithmetic and the documented handshake latency.
module tb_seq_mod_unit;

  localparam int DW  = 64;
  localparam int LAT = DW + 1;

  logic          Clk;
  logic          Rst;
  logic          start;
  logic [DW-1:0] a;
  logic [DW-1:0] c;
  logic          busy;
  logic          done;
  logic [DW-1:0] rem;
  logic [DW-1:0] quot;
  logic          dz;

  int errors = 0;
  int checks = 0;

  seq_mod_unit #(.DATAWIDTH(DW)) dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .start(start),
    .a    (a),
    .c    (c),
    .busy (busy),
    .done (done),
    .rem  (rem),
    .quot (quot),
    .dz   (dz)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Issues one request at a negedge and waits (bounded) for done; called and left at a negedge.
  task automatic drive_op(input logic [DW-1:0] ta, input logic [DW-1:0] tc,
                          output int lat, output int bcy, output bit seen);
    a = ta;
    c = tc;
    start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    start = 1'b0;
    lat = 0;
    bcy = 0;
    seen = 1'b0;
    while (lat <= 200) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) bcy++;
      @(negedge Clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    start = 1'b0;
    a = '0;
    c = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (rem !== '0) begin errors++; $display("FAIL reset_rem got=%0d want=0", rem); end
    checks++; if (quot !== '0) begin errors++; $display("FAIL reset_quot got=%0d want=0", quot); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL reset_dz got=%b want=0", dz); end
  endtask

  task automatic test_basic();
    int lat, bcy;
    bit seen;
    drive_op(64'd100, 64'd7, lat, bcy, seen);
    $display("op a=100 c=7 quot=%0d rem=%0d dz=%b lat=%0d busy_cycles=%0d", quot, rem, dz, lat, bcy);
    checks++; if (!seen) begin errors++; $display("FAIL basic_timeout got=no_done want=done"); end
    checks++; if (lat != LAT) begin errors++; $display("FAIL basic_latency got=%0d want=%0d", lat, LAT); end
    checks++; if (bcy != DW) begin errors++; $display("FAIL basic_busy_cycles got=%0d want=%0d", bcy, DW); end
    checks++; if (quot !== 64'd14) begin errors++; $display("FAIL basic_quot got=%0d want=14", quot); end
    checks++; if (rem !== 64'd2) begin errors++; $display("FAIL basic_rem got=%0d want=2", rem); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL basic_dz got=%b want=0", dz); end
    @(negedge Clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b want=0", done); end
    repeat (3) @(negedge Clk);
    checks++; if (quot !== 64'd14 || rem !== 64'd2) begin
      errors++; $display("FAIL basic_hold got=%0d/%0d want=14/2", quot, rem);
    end
  endtask

  task automatic test_vectors();
    logic [DW-1:0] va [$];
    logic [DW-1:0] vc [$];
    logic [DW-1:0] eq, er;
    logic          ed;
    int            el, lat, bcy;
    bit            seen;
    va = '{64'd84, 64'd5, {DW{1'b1}}, 64'd37};
    vc = '{64'd7, 64'd9, 64'd1, 64'd0};
    for (int i = 0; i < 8; i++) begin
      va.push_back({$urandom, $urandom});
      case ($urandom_range(0, 3))
        0:       vc.push_back(DW'($urandom_range(1, 20)));
        1:       vc.push_back({32'd0, $urandom});
        2:       vc.push_back({$urandom, $urandom});
        default: vc.push_back(64'd0);
      endcase
    end
    for (int i = 0; i < va.size(); i++) begin
      if (vc[i] == 0) begin
        eq = {DW{1'b1}}; er = va[i]; ed = 1'b1; el = 1;
      end else begin
        eq = va[i] / vc[i]; er = va[i] % vc[i]; ed = 1'b0; el = LAT;
      end
      drive_op(va[i], vc[i], lat, bcy, seen);
      $display("op a=%0d c=%0d quot=%0d rem=%0d dz=%b lat=%0d", va[i], vc[i], quot, rem, dz, lat);
      checks++; if (!seen) begin errors++; $display("FAIL vec%0d_timeout got=no_done want=done", i); end
      checks++; if (lat != el) begin errors++; $display("FAIL vec%0d_latency got=%0d want=%0d", i, lat, el); end
      checks++; if (quot !== eq) begin errors++; $display("FAIL vec%0d_quot got=%0d want=%0d", i, quot, eq); end
      checks++; if (rem !== er) begin errors++; $display("FAIL vec%0d_rem got=%0d want=%0d", i, rem, er); end
      checks++; if (dz !== ed) begin errors++; $display("FAIL vec%0d_dz got=%b want=%b", i, dz, ed); end
      @(negedge Clk);
    end
  endtask

  task automatic test_back_to_back();
    int  n;
    int  ndone;
    a = 64'd10;
    c = 64'd3;
    start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    a = 64'd9;
    c = 64'd4;
    n = 0;
    ndone = 0;
    while (n <= 300 && ndone < 2) begin
      if (n == 30) begin a = {$urandom, $urandom}; c = 64'd1; end
      if (n == 50) begin a = 64'd9; c = 64'd4; end
      if (done) begin
        ndone++;
        $display("op b2b#%0d quot=%0d rem=%0d at=%0d", ndone, quot, rem, n);
        if (ndone == 1) begin
          checks++; if (n != LAT) begin errors++; $display("FAIL b2b1_latency got=%0d want=%0d", n, LAT); end
          checks++; if (quot !== 64'd3 || rem !== 64'd1) begin
            errors++; $display("FAIL b2b1_result got=%0d/%0d want=3/1", quot, rem);
          end
          checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_started got=%b want=1", busy); end
          start = 1'b0;
        end else begin
          checks++; if (n != 2 * LAT) begin errors++; $display("FAIL b2b2_latency got=%0d want=%0d", n, 2 * LAT); end
          checks++; if (quot !== 64'd2 || rem !== 64'd1) begin
            errors++; $display("FAIL b2b2_result got=%0d/%0d want=2/1", quot, rem);
          end
        end
      end
      @(negedge Clk);
      n++;
    end
    start = 1'b0;
    checks++; if (ndone != 2) begin errors++; $display("FAIL b2b_done_count got=%0d want=2", ndone); end
  endtask

  task automatic test_reset_midrun();
    int  lat, bcy;
    bit  seen;
    bit  stray;
    a = 64'd1000;
    c = 64'd3;
    start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    start = 1'b0;
    repeat (19) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || dz !== 1'b0) begin
      errors++; $display("FAIL midreset_flags got=busy%b done%b dz%b want=000", busy, done, dz);
    end
    checks++; if (rem !== '0 || quot !== '0) begin
      errors++; $display("FAIL midreset_outputs got=%0d/%0d want=0/0", quot, rem);
    end
    stray = 1'b0;
    repeat (80) begin
      @(negedge Clk);
      if (done || busy) stray = 1'b1;
    end
    checks++; if (stray) begin errors++; $display("FAIL midreset_no_done got=activity want=idle"); end
    drive_op(64'd50, 64'd6, lat, bcy, seen);
    $display("op a=50 c=6 quot=%0d rem=%0d dz=%b lat=%0d", quot, rem, dz, lat);
    checks++; if (!seen || lat != LAT) begin errors++; $display("FAIL fresh_latency got=%0d want=%0d", lat, LAT); end
    checks++; if (quot !== 64'd8 || rem !== 64'd2) begin
      errors++; $display("FAIL fresh_result got=%0d/%0d want=8/2", quot, rem);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
